// File: rtl/pulse_stretcher.sv
// pulse_stretcher: stretches a single-cycle tick into an ON level of 2^ON_BITS
// cycles followed by a forced OFF gap of 2^GAP_BITS cycles. One event can be
// queued while busy; further events are dropped and flagged on overrun.
// Optional build macro PULSE_STRETCHER_RETRIG_EN: a tick during ON restarts
// the ON window instead of queueing.
module pulse_stretcher #(
    parameter int unsigned ON_BITS  = 20,
    parameter int unsigned GAP_BITS = 19
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_in,
    output logic level_out,
    output logic busy,
    output logic done_tick,
    output logic overrun
);

    localparam int unsigned Q_W = (ON_BITS > GAP_BITS) ? ON_BITS : GAP_BITS;
    localparam logic [Q_W-1:0] ON_RELOAD  = Q_W'((64'd1 << ON_BITS) - 64'd1);
    localparam logic [Q_W-1:0] GAP_RELOAD = Q_W'((64'd1 << GAP_BITS) - 64'd1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ON   = 2'b01,
        ST_GAP  = 2'b10
    } state_t;

    state_t         state_reg;
    logic [Q_W-1:0] q_reg;
    logic           pend_reg;
    logic           level_reg;

    logic q_zero;
    logic retrig_hit;
    logic gap_last;
    logic tick_queues;

    // Decode of the counter terminal value and of where an incoming tick goes
    assign q_zero   = (q_reg == '0);
    assign gap_last = (state_reg == ST_GAP) && q_zero;

`ifdef PULSE_STRETCHER_RETRIG_EN
    assign retrig_hit = (state_reg == ST_ON) && tick_in;
`else
    assign retrig_hit = 1'b0;
`endif

    // A tick queues when it is neither consumed by a transition nor a retrigger
    assign tick_queues = ((state_reg == ST_ON) && !retrig_hit) ||
                         ((state_reg == ST_GAP) && !q_zero);

    // Status outputs decoded from registered state (plus the live tick)
    assign level_out = level_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign done_tick = (state_reg == ST_ON) && q_zero && !retrig_hit;
    assign overrun   = tick_in && pend_reg && (tick_queues || gap_last);

    // Sequencer: idle -> on (2^ON_BITS) -> gap (2^GAP_BITS) -> idle or on
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            q_reg     <= '0;
            pend_reg  <= 1'b0;
            level_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (tick_in) begin
                        state_reg <= ST_ON;
                        q_reg     <= ON_RELOAD;
                        level_reg <= 1'b1;
                    end
                end
                ST_ON: begin
                    if (tick_in && !retrig_hit) begin
                        pend_reg <= 1'b1;
                    end
                    if (retrig_hit) begin
                        q_reg <= ON_RELOAD;
                    end else if (q_zero) begin
                        state_reg <= ST_GAP;
                        q_reg     <= GAP_RELOAD;
                        level_reg <= 1'b0;
                    end else begin
                        q_reg <= q_reg - Q_W'(1);
                    end
                end
                ST_GAP: begin
                    if (q_zero) begin
                        pend_reg <= 1'b0;
                        if (pend_reg || tick_in) begin
                            state_reg <= ST_ON;
                            q_reg     <= ON_RELOAD;
                            level_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end else begin
                        q_reg <= q_reg - Q_W'(1);
                        if (tick_in) begin
                            pend_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    q_reg     <= '0;
                    pend_reg  <= 1'b0;
                    level_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Testbench for pulse_stretcher (ON_BITS=3, GAP_BITS=2). The reference model
// tracks absolute end-of-ON / end-of-gap cycle numbers and a pending flag.
module tb_pulse_stretcher;

    localparam int ON_CYC  = 8;
    localparam int GAP_CYC = 4;
`ifdef PULSE_STRETCHER_RETRIG_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic clk;
    logic reset;
    logic tick_in;
    logic level_out;
    logic busy;
    logic done_tick;
    logic overrun;

    int n_cmp;
    int n_err;

    // model state: absolute cycle numbers within the current segment
    int cyc;
    int on_end;
    int gap_end;
    bit pend;
    int sched[$];

    pulse_stretcher #(.ON_BITS(3), .GAP_BITS(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .tick_in   (tick_in),
        .level_out (level_out),
        .busy      (busy),
        .done_tick (done_tick),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @seg_cycle %0d: got %b expected %b", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        cyc     = 0;
        on_end  = -1;
        gap_end = -1;
        pend    = 1'b0;
    endtask

    // Reset the DUT synchronously to the bench and check the reset state
    task automatic do_reset();
        reset   = 1'b1;
        tick_in = 1'b0;
        @(posedge clk);
        #1;
        check("rst_level", level_out, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done_tick, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        reset = 1'b0;
        model_reset();
    endtask

    // Runs n cycles; ticks come from sched (segment cycle numbers) or random
    task automatic run_cycles(input int n, input int density);
        bit t;
        bit in_on;
        bit in_gap;
        bit e_ovr;
        bit e_done;
        for (int k = 0; k < n; k++) begin
            t = 1'b0;
            foreach (sched[i]) if (sched[i] == cyc) t = 1'b1;
            if (density > 0 && $urandom_range(99) < density) t = 1'b1;
            tick_in = t;
            #1;
            in_on  = (cyc <= on_end);
            in_gap = !in_on && (cyc <= gap_end);
            e_done = in_on && (cyc == on_end) && !(RETRIG && t);
            e_ovr  = t && pend && (in_gap || (in_on && !RETRIG));
            check("level_out", level_out, in_on);
            check("busy", busy, in_on || in_gap);
            check("done_tick", done_tick, e_done);
            check("overrun", overrun, e_ovr);
            // advance the model
            if (in_on) begin
                if (t && RETRIG) begin
                    on_end  = cyc + ON_CYC;
                    gap_end = on_end + GAP_CYC;
                end else if (t) begin
                    pend = 1'b1;
                end
            end else if (in_gap) begin
                if (cyc == gap_end) begin
                    if (pend || t) begin
                        on_end  = cyc + ON_CYC;
                        gap_end = on_end + GAP_CYC;
                    end
                    pend = 1'b0;
                end else if (t) begin
                    pend = 1'b1;
                end
            end else if (t) begin
                on_end  = cyc + ON_CYC;
                gap_end = on_end + GAP_CYC;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        tick_in = 1'b0;
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        reset   = 1'b1;
        tick_in = 1'b0;
        model_reset();
        #12;

        // single tick from idle
        do_reset();
        sched = '{0};
        run_cycles(20, 0);

        // second tick during ON (retrigger case when the macro is defined)
        do_reset();
        sched = '{0, 4};
        run_cycles(30, 0);

        // one queued, two dropped
        do_reset();
        sched = '{0, 3, 5, 6};
        run_cycles(40, 0);

        // tick exactly on the last gap cycle, nothing pending
        do_reset();
        sched = '{0, 12};
        run_cycles(30, 0);

        // tick on the last ON cycle and on the last gap cycle with pending set
        do_reset();
        sched = '{0, 8, 12};
        run_cycles(40, 0);

        // retrigger-style pattern
        do_reset();
        sched = '{0, 6};
        run_cycles(30, 0);

        // asynchronous reset mid-ON with an event pending
        do_reset();
        sched = '{0, 3};
        run_cycles(5, 0);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_level", level_out, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        do_reset();
        sched = {};
        run_cycles(25, 0);

        // randomized traffic at several densities
        for (int d = 0; d < 4; d++) begin
            do_reset();
            sched = {};
            run_cycles(300, (d == 0) ? 3 : (d == 1) ? 10 : (d == 2) ? 30 : 70);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
